// File: rtl/note_sequencer_pkg.sv
// Shared constants for the note sequencer: state encodings,
// button indices and register widths.
package seq_pkg;

    localparam int STATE_W = 2;
    localparam int TEMPO_W = 2;
    localparam int NUM_BTNS = 4;

    localparam logic [STATE_W-1:0] ST_PLAY    = 2'b00;
    localparam logic [STATE_W-1:0] ST_REVERSE = 2'b01;
    localparam logic [STATE_W-1:0] ST_PAUSED  = 2'b10;
    localparam logic [STATE_W-1:0] ST_EDIT    = 2'b11;

    localparam int BTN_PLAY = 0;
    localparam int BTN_REV  = 1;
    localparam int BTN_EDIT = 2;
    localparam int BTN_AUX  = 3;

endpackage

// File: rtl/note_ram.sv
// Note table: register file with asynchronous read and synchronous write.
// Ports: clk, rst (sync, loads INIT everywhere), we, addr, wdata, rdata.
module note_ram #(
    parameter int               DEPTH = 8,
    parameter int               WIDTH = 24,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: steps through the note table at a selectable tempo and
// drives the NCO fcw; supports reverse play, pause and per-note editing.
// Ports: clk, rst (sync, active-high), buttons[3:0] (single-cycle pulses),
//        fcw (to NCO), leds (one-hot address), leds_state, tempo.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int CYCLES_PER_SECOND = 125_000_000,
    parameter int NUM_NOTES         = 8,
    parameter int FCW_WIDTH         = 24,
    parameter int FCW_MIN           = 2748,
    parameter int FCW_MAX           = 274877,
    parameter int FCW_STEP          = 1024,
    parameter int FCW_INIT          = 59055
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTNS-1:0]  buttons,
    output logic [FCW_WIDTH-1:0] fcw,
    output logic [NUM_NOTES-1:0] leds,
    output logic [STATE_W-1:0]   leds_state,
    output logic [TEMPO_W-1:0]   tempo
);

    localparam int ADDR_W  = $clog2(NUM_NOTES);
    localparam int TIMER_W = $clog2(CYCLES_PER_SECOND + 1);
    localparam int XW      = FCW_WIDTH + 1;

    localparam logic [TIMER_W-1:0] PERIOD0 = TIMER_W'(CYCLES_PER_SECOND);
    localparam logic [XW-1:0] MIN_X  = XW'(FCW_MIN);
    localparam logic [XW-1:0] MAX_X  = XW'(FCW_MAX);
    localparam logic [XW-1:0] STEP_X = XW'(FCW_STEP);
    localparam logic [NUM_NOTES-1:0] LED_ONE = NUM_NOTES'(1);

    logic [STATE_W-1:0]   state, state_n;
    logic [TEMPO_W-1:0]   tempo_q, tempo_n;
    logic [ADDR_W-1:0]    addr, addr_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [TIMER_W-1:0]   period;
    logic [NUM_BTNS-1:0]  btn_top;
    logic                 we;
    logic [FCW_WIDTH-1:0] wdata;
    logic [FCW_WIDTH-1:0] rdata;
    logic [XW-1:0]        rd_x, dec_x, inc_x, diff_x, sum_x;
    logic                 moving, changed, expire;

    note_ram #(
        .DEPTH (NUM_NOTES),
        .WIDTH (FCW_WIDTH),
        .INIT  (FCW_WIDTH'(FCW_INIT))
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Isolate the lowest set bit: bit 0 has the highest priority.
    assign btn_top = buttons & (~buttons + NUM_BTNS'(1));

    // Saturating edits. The clamp on both bounds pulls an out-of-range
    // entry back into range on its first edit.
    always_comb begin
        rd_x   = {1'b0, rdata};
        diff_x = rd_x - STEP_X;
        sum_x  = rd_x + STEP_X;

        if (rd_x < MIN_X + STEP_X) begin
            dec_x = MIN_X;
        end else if (diff_x > MAX_X) begin
            dec_x = MAX_X;
        end else begin
            dec_x = diff_x;
        end

        if (sum_x > MAX_X) begin
            inc_x = MAX_X;
        end else if (sum_x < MIN_X) begin
            inc_x = MIN_X;
        end else begin
            inc_x = sum_x;
        end
    end

    always_comb begin
        state_n = state;
        tempo_n = tempo_q;
        addr_n  = addr;
        we      = 1'b0;
        wdata   = rdata;

        unique case (state)
            ST_PLAY, ST_REVERSE: begin
                unique case (1'b1)
                    btn_top[BTN_PLAY]: state_n = ST_PAUSED;
                    btn_top[BTN_REV]:
                        state_n = (state == ST_PLAY) ? ST_REVERSE : ST_PLAY;
                    btn_top[BTN_EDIT]: ;
                    btn_top[BTN_AUX]: tempo_n = tempo_q + TEMPO_W'(1);
                    default: ;
                endcase
            end
            ST_PAUSED: begin
                unique case (1'b1)
                    btn_top[BTN_PLAY]: state_n = ST_PLAY;
                    btn_top[BTN_REV]:  ;
                    btn_top[BTN_EDIT]: state_n = ST_EDIT;
                    btn_top[BTN_AUX]:  ;
                    default: ;
                endcase
            end
            ST_EDIT: begin
                unique case (1'b1)
                    btn_top[BTN_PLAY]: begin
                        we    = 1'b1;
                        wdata = dec_x[FCW_WIDTH-1:0];
                    end
                    btn_top[BTN_REV]: begin
                        we    = 1'b1;
                        wdata = inc_x[FCW_WIDTH-1:0];
                    end
                    btn_top[BTN_EDIT]: state_n = ST_PAUSED;
                    btn_top[BTN_AUX]:  addr_n = addr + ADDR_W'(1);
                    default: ;
                endcase
            end
            default: ;
        endcase

        // A state or tempo change restarts the note period, so it also
        // suppresses an advance that would otherwise land this cycle.
        period  = PERIOD0 >> tempo_q;
        moving  = (state == ST_PLAY) || (state == ST_REVERSE);
        changed = (state_n != state) || (tempo_n != tempo_q);
        expire  = moving && !changed && (timer == period - TIMER_W'(1));

        if (!moving || changed || expire) begin
            timer_n = '0;
        end else begin
            timer_n = timer + TIMER_W'(1);
        end

        if (expire) begin
            addr_n = (state == ST_PLAY) ? addr + ADDR_W'(1)
                                        : addr - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PLAY;
            tempo_q <= '0;
            addr    <= '0;
            timer   <= '0;
        end else begin
            state   <= state_n;
            tempo_q <= tempo_n;
            addr    <= addr_n;
            timer   <= timer_n;
        end
    end

    assign fcw        = (state == ST_PAUSED) ? '0 : rdata;
    assign leds       = LED_ONE << addr;
    assign leds_state = state;
    assign tempo      = tempo_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (4 notes, 16 cycles per note).
// Expected outputs are queued on drive and compared after the clock edge.
module tb_note_sequencer;

    localparam int CPS  = 16;
    localparam int NN   = 4;
    localparam int FW   = 24;
    localparam int FMIN = 2748;
    localparam int FMAX = 274877;
    localparam int STEP = 1024;
    localparam int INIT = 59055;

    localparam logic [1:0] S_PLAY = 2'b00;
    localparam logic [1:0] S_REV  = 2'b01;
    localparam logic [1:0] S_PAU  = 2'b10;
    localparam logic [1:0] S_EDIT = 2'b11;

    typedef struct {
        logic [FW-1:0] fcw;
        logic [NN-1:0] leds;
        logic [1:0]    st;
        logic [1:0]    tp;
        string         name;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        exp_t       e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    buttons = '0;
    logic [FW-1:0] fcw;
    logic [NN-1:0] leds;
    logic [1:0]    leds_state;
    logic [1:0]    tempo;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t tbl[6];

    note_sequencer #(
        .CYCLES_PER_SECOND (CPS),
        .NUM_NOTES         (NN),
        .FCW_WIDTH         (FW),
        .FCW_MIN           (FMIN),
        .FCW_MAX           (FMAX),
        .FCW_STEP          (STEP),
        .FCW_INIT          (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .fcw        (fcw),
        .leds       (leds),
        .leds_state (leds_state),
        .tempo      (tempo)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int f, input int a, input logic [1:0] s,
                                input logic [1:0] t, input string n);
        exp_t e;
        e.fcw  = FW'(f);
        e.leds = NN'(1) << a;
        e.st   = s;
        e.tp   = t;
        e.name = n;
        return e;
    endfunction

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (fcw !== e.fcw || leds !== e.leds ||
            leds_state !== e.st || tempo !== e.tp) begin
            failures++;
            $display("FAIL %s: got fcw=%0d leds=%b st=%b tempo=%0d, want fcw=%0d leds=%b st=%b tempo=%0d",
                     e.name, fcw, leds, leds_state, tempo,
                     e.fcw, e.leds, e.st, e.tp);
        end
    endtask

    task automatic drive(input logic [3:0] b, input logic r, input exp_t e);
        @(negedge clk);
        buttons = b;
        rst     = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        buttons = '0;
        rst     = 1'b0;
        compare();
    endtask

    initial begin
        int v;
        int a;

        tbl[0] = '{4'b0100, mk(INIT,          2, S_EDIT, 0, "edit_enter")};
        tbl[1] = '{4'b0010, mk(INIT + STEP,   2, S_EDIT, 0, "edit_inc1")};
        tbl[2] = '{4'b0010, mk(INIT + 2*STEP, 2, S_EDIT, 0, "edit_inc2")};
        tbl[3] = '{4'b1000, mk(INIT,          3, S_EDIT, 0, "edit_next")};
        tbl[4] = '{4'b0100, mk(0,             3, S_PAU,  0, "edit_exit")};
        tbl[5] = '{4'b0001, mk(INIT,          3, S_PLAY, 0, "resume")};

        drive(4'b0000, 1'b1, mk(INIT, 0, S_PLAY, 0, "reset"));

        for (int i = 1; i <= 64; i++) begin
            drive(4'b0000, 1'b0, mk(INIT, (i / 16) % 4, S_PLAY, 0, "play_idle"));
        end

        drive(4'b1000, 1'b0, mk(INIT, 0, S_PLAY, 1, "tempo1"));
        for (int i = 1; i <= 8; i++) begin
            drive(4'b0000, 1'b0, mk(INIT, (i == 8) ? 1 : 0, S_PLAY, 1, "tempo1_run"));
        end
        drive(4'b1000, 1'b0, mk(INIT, 1, S_PLAY, 2, "tempo2"));
        drive(4'b1000, 1'b0, mk(INIT, 1, S_PLAY, 3, "tempo3"));
        drive(4'b1000, 1'b0, mk(INIT, 1, S_PLAY, 0, "tempo_wrap"));

        drive(4'b0010, 1'b0, mk(INIT, 1, S_REV, 0, "reverse"));
        for (int i = 1; i <= 48; i++) begin
            a = (1 - i / 16 + 4) % 4;
            drive(4'b0000, 1'b0, mk(INIT, a, S_REV, 0, "reverse_run"));
        end
        drive(4'b0010, 1'b0, mk(INIT, 2, S_PLAY, 0, "back_to_play"));

        drive(4'b0001, 1'b0, mk(0, 2, S_PAU, 0, "pause"));
        for (int i = 0; i < 40; i++) begin
            drive(4'b0000, 1'b0, mk(0, 2, S_PAU, 0, "pause_hold"));
        end

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].btn, 1'b0, tbl[i].e);
        end

        for (int i = 1; i <= 48; i++) begin
            a = (3 + i / 16) % 4;
            drive(4'b0000, 1'b0,
                  mk((a == 2) ? INIT + 2*STEP : INIT, a, S_PLAY, 0, "replay"));
        end

        drive(4'b0001, 1'b0, mk(0, 2, S_PAU, 0, "pause2"));
        v = INIT + 2*STEP;
        drive(4'b0100, 1'b0, mk(v, 2, S_EDIT, 0, "edit2"));
        for (int i = 0; i < 60; i++) begin
            v = (v - STEP < FMIN) ? FMIN : v - STEP;
            drive(4'b0001, 1'b0, mk(v, 2, S_EDIT, 0, "sat_dec"));
        end
        for (int i = 0; i < 300; i++) begin
            v = (v + STEP > FMAX) ? FMAX : v + STEP;
            drive(4'b0010, 1'b0, mk(v, 2, S_EDIT, 0, "sat_inc"));
        end

        drive(4'b0100, 1'b0, mk(0, 2, S_PAU, 0, "pause3"));
        drive(4'b0001, 1'b0, mk(FMAX, 2, S_PLAY, 0, "play_max"));
        drive(4'b1100, 1'b0, mk(FMAX, 2, S_PLAY, 0, "edit_masks_aux"));
        drive(4'b0011, 1'b0, mk(0, 2, S_PAU, 0, "dual_press"));
        drive(4'b0100, 1'b0, mk(FMAX, 2, S_EDIT, 0, "edit3"));
        drive(4'b0010, 1'b0, mk(FMAX, 2, S_EDIT, 0, "inc_at_max"));
        drive(4'b0001, 1'b0, mk(FMAX - STEP, 2, S_EDIT, 0, "dec_from_max"));

        drive(4'b0001, 1'b1, mk(INIT, 0, S_PLAY, 0, "reset_in_edit"));
        drive(4'b0001, 1'b0, mk(0, 0, S_PAU, 0, "pause4"));
        drive(4'b0100, 1'b0, mk(INIT, 0, S_EDIT, 0, "edit4"));
        drive(4'b1000, 1'b0, mk(INIT, 1, S_EDIT, 0, "next1"));
        drive(4'b1000, 1'b0, mk(INIT, 2, S_EDIT, 0, "entry_reset"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
